// File: rtl/pipe_sel_mux_pkg.sv
// Shared definitions for the RV32 operand-forwarding select stage.
// Holds the forward-select encodings, default sizes and a saturating-increment helper.
package pipe_sel_mux_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // Snapshot of the error status, handy for binding checkers to one signal.
  typedef struct packed {
    logic       sticky;
    logic [7:0] count;
  } err_status_t;

  // Increment by one, holding at the all-ones value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned w);
    logic [31:0] max_val;
    max_val = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    sat_inc = (val >= max_val) ? max_val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/pipe_sel_mux_sat_counter.sv
// Saturating up-counter with synchronous clear; an increment in the same cycle as a
// clear restarts the count at one so the triggering event is never lost.
module sat_counter
  import pipe_sel_mux_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [31:0]      count_ext;
  logic [31:0]      count_inc;

  assign count_ext = 32'(count_q);
  assign count_inc = sat_inc(count_ext, CNT_W);

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = clr ? CNT_W'(1) : count_inc[CNT_W-1:0];
    end else if (clr) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_sel_mux.sv
// Registered N-way operand select with stall/flush and illegal-select error status.
// Stream semantics: in_valid qualifies in_data/sel on a load edge; there is no ready --
// stall holds the stage, flush inserts a bubble (flush > stall > load).
module pipe_sel_mux
  import pipe_sel_mux_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    err_clr,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    err_sticky,
  output logic [CNT_W-1:0]        err_count,
  output logic [SEL_W-1:0]        err_sel
);

  if (NUM_IN < 2 || NUM_IN > 16 || (1 << SEL_W) < NUM_IN) begin : g_bad_params
    $error("pipe_sel_mux: NUM_IN must be 2..16 and fit in SEL_W bits");
  end

  logic [WIDTH-1:0] sel_data;
  logic             sel_legal;
  logic             load;
  logic             err_event;

  logic [WIDTH-1:0] data_q,   data_d;
  logic             valid_q,  valid_d;
  logic             sticky_q, sticky_d;
  logic [SEL_W-1:0] esel_q,   esel_d;

  // An equality test against an X/Z select is never true, so unknown selects fall
  // through to the zero default and are flagged illegal.
  always_comb begin
    sel_data  = '0;
    sel_legal = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data  = in_data[k*WIDTH +: WIDTH];
        sel_legal = 1'b1;
      end
    end
  end

  assign load      = !flush && !stall;
  assign err_event = load && in_valid && !sel_legal;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      data_d  = sel_data;
      valid_d = in_valid;
    end
  end

  // Clear is independent of stall/flush; a same-cycle error event takes precedence.
  always_comb begin
    sticky_d = sticky_q;
    esel_d   = esel_q;
    if (err_event) begin
      sticky_d = 1'b1;
      esel_d   = sel;
    end else if (err_clr) begin
      sticky_d = 1'b0;
      esel_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      sticky_q <= 1'b0;
      esel_q   <= '0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      sticky_q <= sticky_d;
      esel_q   <= esel_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (err_clr),
    .inc   (err_event),
    .count (err_count)
  );

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign err_sticky = sticky_q;
  assign err_sel    = esel_q;

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Directed bench for pipe_sel_mux: a default instance (CNT_W=8) and a CNT_W=2 instance
// share one stimulus stream so saturation can be observed alongside normal counting.
module tb_pipe_sel_mux;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int SW = 2;

  localparam logic [W-1:0] DA = 32'h1111_1111;
  localparam logic [W-1:0] DB = 32'h2222_2222;
  localparam logic [W-1:0] DC = 32'h3333_3333;

  logic          clk;
  logic          reset;
  logic [N*W-1:0] in_data;
  logic [SW-1:0] sel;
  logic          in_valid;
  logic          stall;
  logic          flush;
  logic          err_clr;

  logic [W-1:0]  out_data,   s_out_data;
  logic          out_valid,  s_out_valid;
  logic          err_sticky, s_err_sticky;
  logic [7:0]    err_count;
  logic [1:0]    s_err_count;
  logic [SW-1:0] err_sel,    s_err_sel;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_d;
  logic [W-1:0] table_v[3];

  pipe_sel_mux #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .err_clr(err_clr),
    .out_data(out_data), .out_valid(out_valid), .err_sticky(err_sticky),
    .err_count(err_count), .err_sel(err_sel)
  );

  pipe_sel_mux #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .err_clr(err_clr),
    .out_data(s_out_data), .out_valid(s_out_valid), .err_sticky(s_err_sticky),
    .err_count(s_err_count), .err_sel(s_err_sel)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance one active edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_err(input string tag, input logic sticky, input logic [7:0] cnt,
                         input logic [1:0] scnt, input logic [SW-1:0] esel);
    chk({tag, "_sticky"}, W'(err_sticky), W'(sticky));
    chk({tag, "_count"}, W'(err_count), W'(cnt));
    chk({tag, "_s_count"}, W'(s_err_count), W'(scnt));
    chk({tag, "_err_sel"}, W'(err_sel), W'(esel));
  endtask

  initial begin
    table_v[0] = DA; table_v[1] = DB; table_v[2] = DC;
    reset = 1'b1; in_data = '0; sel = '0; in_valid = 1'b0;
    stall = 1'b0; flush = 1'b0; err_clr = 1'b0;
    step(); step();
    chk("rst_data", out_data, '0);
    chk("rst_valid", W'(out_valid), '0);
    chk_err("rst", 1'b0, 8'd0, 2'd0, 2'd0);
    reset = 1'b0;

    // legal loads through the expected queue
    in_data = {DC, DB, DA};
    in_valid = 1'b1;
    exp_q.push_back(DA); exp_q.push_back(DB); exp_q.push_back(DC);
    for (int i = 0; i < 3; i++) begin
      sel = SW'(i);
      step();
      exp_d = exp_q.pop_front();
      chk($sformatf("load_sel%0d", i), out_data, exp_d);
      chk($sformatf("load_valid%0d", i), W'(out_valid), W'(1));
    end

    // asynchronous reset mid-cycle
    #2 reset = 1'b1;
    #1;
    chk("areset_data", out_data, '0);
    chk("areset_valid", W'(out_valid), '0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("post_reset_valid", W'(out_valid), '0);

    // illegal select, valid and then not valid
    sel = 2'd3; in_valid = 1'b1;
    step();
    chk("ill_data", out_data, '0);
    chk("ill_valid", W'(out_valid), W'(1));
    chk_err("ill", 1'b1, 8'd1, 2'd1, 2'd3);
    in_valid = 1'b0;
    step();
    chk("ill_nv_valid", W'(out_valid), '0);
    chk_err("ill_nv", 1'b1, 8'd1, 2'd1, 2'd3);

    // stall holds data and error state
    sel = 2'd1; in_valid = 1'b1;
    step();
    chk("pre_stall", out_data, DB);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = {$urandom(), $urandom(), $urandom()};
      sel = (i == 1) ? 2'd3 : SW'(i);
      in_valid = 1'b1;
      step();
      chk($sformatf("stall_data%0d", i), out_data, DB);
      chk($sformatf("stall_valid%0d", i), W'(out_valid), W'(1));
      chk($sformatf("stall_cnt%0d", i), W'(err_count), W'(1));
    end
    in_data = {DC, DB, DA};

    // flush overrides stall; flush logs no error
    flush = 1'b1; sel = 2'd2;
    step();
    chk("flush_stall_valid", W'(out_valid), '0);
    chk("flush_stall_data", out_data, '0);
    stall = 1'b0; sel = 2'd3; in_valid = 1'b1;
    step();
    chk("flush_ill_valid", W'(out_valid), '0);
    chk_err("flush_ill", 1'b1, 8'd1, 2'd1, 2'd3);
    flush = 1'b0;

    // err_clr alone
    err_clr = 1'b1; in_valid = 1'b0; sel = 2'd0;
    step();
    chk_err("clr", 1'b0, 8'd0, 2'd0, 2'd0);
    err_clr = 1'b0;

    // five illegal events: saturate the 2-bit counter
    sel = 2'd3; in_valid = 1'b1;
    repeat (5) step();
    chk_err("sat", 1'b1, 8'd5, 2'd3, 2'd3);
    chk("sat_s_sticky", W'(s_err_sticky), W'(1));

    // clear together with an event: the event wins
    err_clr = 1'b1;
    step();
    chk_err("clr_ev", 1'b1, 8'd1, 2'd1, 2'd3);
    err_clr = 1'b0;

    // legal load after errors leaves status untouched
    sel = 2'd2;
    step();
    chk("legal_after", out_data, DC);
    chk_err("legal_after", 1'b1, 8'd1, 2'd1, 2'd3);

    // unknown select
    err_clr = 1'b1; in_valid = 1'b0;
    step();
    err_clr = 1'b0;
    sel = 'x; in_valid = 1'b1;
    step();
    if ($isunknown(sel)) begin
      chk("xsel_data", out_data, '0);
      chk("xsel_sticky", W'(err_sticky), W'(1));
    end else begin
      exp_d = (sel < 2'd3) ? table_v[sel] : '0;
      chk("xsel_data", out_data, exp_d);
      chk("xsel_sticky", W'(err_sticky), W'(sel == 2'd3));
    end
    chk("xsel_known", W'($isunknown(out_data)), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_sel_mux.md
Name: pipe_sel_mux

Overview:
- Parametrised, registered N-way operand select stage for the RV32 pipeline, e.g. the ALU operand forwarding select between the register file, EX/MEM and MEM/WB.
- Replaces fixed-width combinational 3:1 selection with a 1-cycle pipeline register.
- Adds stall/flush control and deterministic handling of illegal selects.
- Illegal-select events are made visible through sticky and counted error status.

Parameters:
- WIDTH, 32, data width of each input and the output
- NUM_IN, 3, number of selectable inputs (2..16)
- SEL_W, 2, select width; must satisfy 2^SEL_W >= NUM_IN
- CNT_W, 8, width of the saturating illegal-select counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
- sel  input  SEL_W  index of the input to forward
- in_valid  input  1  in_data/sel qualify a real instruction this cycle
- stall  input  1  hold the stage register
- flush  input  1  kill the stage contents (bubble)
- err_clr  input  1  clear error status
- out_data  output  WIDTH  registered selected data
- out_valid  output  1  out_data holds a live instruction operand
- err_sticky  output  1  an illegal select has occurred since reset/clear
- err_count  output  CNT_W  saturating count of illegal-select events
- err_sel  output  SEL_W  sel value of the most recent illegal event

Behaviour:
- Reset (asynchronous, active-high): all outputs go to 0 immediately and stay 0 while reset is high.
- Priority each rising edge: flush > stall > load.
- Latency: 1 cycle.
  - On load, out_data <= in_data[sel] and out_valid <= in_valid.
- Legal select: sel < NUM_IN.
- Illegal select: sel >= NUM_IN, or any X/Z bit in simulation (handled by the case default).
  - On load, out_data <= 0 (never X or Z), and out_valid <= in_valid.
  - It is an error event only if in_valid=1 and the cycle is a load. Selects while in_valid=0 are don't-care: data is still loaded per the rules above, but no error is logged.
- Error event effects:
  - err_sticky <= 1
  - err_count increments and saturates at 2^CNT_W-1 (no wrap)
  - err_sel <= sel
- Stall (and no flush): out_data, out_valid and all error state hold. Inputs are ignored and no error is logged.
- Flush: out_valid <= 0 and out_data <= 0. No error is logged that cycle. Flush overrides a simultaneous stall.
- err_clr:
  - Synchronous; clears err_sticky, err_count and err_sel.
  - Independent of stall and flush.
  - If err_clr and an error event occur in the same cycle, the event wins: err_sticky=1, err_count=1, err_sel=sel.
- Reset mid-stall or mid-flush: reset dominates; after release the stage is empty (out_valid=0).
- NUM_IN = 2^SEL_W: no illegal encodings exist except X/Z.
- The module contains no combinational path from inputs to outputs.

Decomposition:
- Shared package/header (same include as the other riscv defines):
  - forward-select encodings: FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2
  - default WIDTH=32 and CNT_W=8
- One natural sub-module: sat_counter (parameter CNT_W; ports clk, reset, clr, inc, count). Used for err_count; reusable elsewhere.
- Selection logic is a loop/case over NUM_IN inside pipe_sel_mux.

Test Plan:
- Reset, then load, with NUM_IN=3, in_data={C,B,A}={0x33333333,0x22222222,0x11111111}, in_valid=1:
  - sel=0,1,2 on consecutive cycles -> out_data is 0x11111111, 0x22222222, 0x33333333 one cycle after each sel, with out_valid=1.
  - Assert reset asynchronously mid-clock -> all outputs 0 before the next edge.
- Illegal select: sel=3 with in_valid=1 -> out_data=0, out_valid=1, err_sticky=1, err_count=1, err_sel=3.
  - Repeat with in_valid=0 -> counters unchanged.
- Stall:
  - Load 0x22222222, then stall=1 for 3 cycles while sel/in_data change -> out_data stays 0x22222222.
  - Also drive sel=3 with in_valid=1 during the stall -> err_count does not increment.
- Flush:
  - flush=1 together with stall=1 -> out_valid=0, out_data=0 next cycle.
  - flush=1 with sel=3, in_valid=1 -> no error logged.
- Error clear and saturation, with CNT_W=2:
  - 5 illegal events -> err_count=3 (saturated).
  - err_clr alone -> all error state 0.
  - err_clr together with an illegal event -> err_count=1, err_sticky=1.
- X select: drive sel=2'bxx with in_valid=1 -> out_data=0 (not X), err_sticky=1.
